// File: rtl/seq_shifter.sv
// Iterative shift/rotate unit: moves the operand one bit position per clock
// until the loaded step count is exhausted, then pulses done for one cycle.
module seq_shifter (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] bits,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_SHR  = 3'd0;
    localparam logic [2:0] OP_SHRA = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    logic [1:0]  state_q, state_d;
    logic [31:0] r_q, r_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Shifts saturate at 32 steps; rotates by 32 or more collapse to no steps.
    function automatic logic [5:0] load_count(input logic [2:0] op_i, input logic [31:0] bits_i);
        logic [5:0] cnt;
        case (op_i)
            OP_SHR, OP_SHRA, OP_SHL: cnt = (bits_i > 32'd32) ? 6'd32 : bits_i[5:0];
            OP_ROR, OP_ROL:          cnt = (bits_i < 32'd32) ? {1'b0, bits_i[4:0]} : 6'd0;
            default:                 cnt = 6'd0;
        endcase
        return cnt;
    endfunction

    function automatic logic [31:0] step_one(input logic [2:0] op_i, input logic [31:0] r_i);
        logic [31:0] r;
        case (op_i)
            OP_SHR:  r = {1'b0, r_i[31:1]};
            OP_SHRA: r = {r_i[31], r_i[31:1]};
            OP_SHL:  r = {r_i[30:0], 1'b0};
            OP_ROR:  r = {r_i[0], r_i[31:1]};
            OP_ROL:  r = {r_i[30:0], r_i[31]};
            default: r = r_i;
        endcase
        return r;
    endfunction

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    r_d     = a;
                    op_d    = op;
                    cnt_d   = load_count(op, bits);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q != 6'd0) begin
                    r_d   = step_one(op_q, r_q);
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and working registers with asynchronous clear.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            r_q     <= 32'h0000_0000;
            cnt_q   <= 6'd0;
            op_q    <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = r_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: the driver queues expected results and
// timing, a separate monitor pops and compares on every done pulse.
module tb_seq_shifter;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] bits;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          acc_cyc;
        int          n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    seq_shifter dut (
        .clock  (clock),
        .clear  (clear),
        .start  (start),
        .op     (op),
        .a      (a),
        .bits   (bits),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    endtask

    task automatic check_int(input string name, input int act, input int exp_v);
        checks++;
        if (act == exp_v) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    endtask

    // Called at a negedge: drives a launch for the next posedge (the accepting edge).
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] res, input int n, input bit push);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = av;
        bits  = bv;
        if (push) begin
            e.res     = res;
            e.acc_cyc = cyc + 1;
            e.n       = n;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
        #1;
        check_int("drain_timeout", sb.size(), 0);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] res, input int n);
        @(negedge clock);
        issue(o, av, bv, res, n, 1'b1);
        @(negedge clock);
        start = 1'b0;
        drain();
    endtask

    // Monitor: done at offset N+1 edges after the accept edge, i.e. latency N+2 cycles.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (clear) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    if (sb.size() == 0) begin
                        check_int("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check32("result", result, e.res);
                        check_int("done_offset", cyc - e.acc_cyc, e.n + 1);
                        check_int("busy_cycles", busy_cnt, e.n + 1);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        clear = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'h0000_0000;
        bits  = 32'h0000_0000;
        #1;
        check32("reset_result", result, 32'h0000_0000);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        repeat (2) @(negedge clock);
        clear = 1'b0;

        run_op(3'd3, 32'h0000_0001, 32'd1,  32'h8000_0000, 1);
        run_op(3'd4, 32'h8000_0001, 32'd4,  32'h0000_0018, 4);
        run_op(3'd1, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 32);
        run_op(3'd0, 32'h8000_0000, 32'd40, 32'h0000_0000, 32);
        run_op(3'd2, 32'h0000_0001, 32'd31, 32'h8000_0000, 31);
        run_op(3'd3, 32'h1234_5678, 32'd32, 32'h1234_5678, 0);
        run_op(3'd3, 32'h1234_5678, 32'd0,  32'h1234_5678, 0);
        run_op(3'd4, 32'h0000_00F1, 32'd33, 32'h0000_00F1, 0);
        run_op(3'd5, 32'hCAFE_BABE, 32'd9,  32'hCAFE_BABE, 0);
        run_op(3'd1, 32'h4000_0000, 32'd2,  32'h1000_0000, 2);
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd32, 32'h0000_0000, 32);

        // Start during RUN is ignored, then a back-to-back launch from DONE.
        @(negedge clock);
        issue(3'd2, 32'h0000_0001, 32'd8, 32'h0000_0100, 8, 1'b1);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        issue(3'd3, 32'hDEAD_BEEF, 32'd3, 32'h0, 0, 1'b0);
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 40 && !done; i++) @(negedge clock);
        check_int("b2b_done_seen", int'(done), 1);
        issue(3'd3, 32'h0000_0001, 32'd1, 32'h8000_0000, 1, 1'b1);
        @(negedge clock);
        start = 1'b0;
        check_int("b2b_busy", int'(busy), 1);
        check_int("b2b_done_low", int'(done), 0);
        drain();

        // Asynchronous clear in the middle of a long shift.
        @(negedge clock);
        issue(3'd0, 32'hFFFF_FFFF, 32'd20, 32'h0, 0, 1'b0);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        #7;
        clear = 1'b1;
        #1;
        check32("clear_result", result, 32'h0000_0000);
        check_int("clear_busy", int'(busy), 0);
        check_int("clear_done", int'(done), 0);
        repeat (2) @(negedge clock);
        clear = 1'b0;
        repeat (30) @(negedge clock);
        check_int("clear_idle_busy", int'(busy), 0);
        run_op(3'd0, 32'hF000_0000, 32'd4, 32'h0F00_0000, 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
